fifo_reader: RTL and testbench
==============================

# fifo_reader

Read-side master for the team's byte FIFO. On a `start` command it drains exactly `len` bytes from the FIFO and presents them on a valid/ready output stream. It tolerates the FIFO running empty mid-transfer and applies backpressure by throttling `fifo_read_en` against a small internal output buffer. It sits between the `fifo` read port and any downstream consumer that requires flow control.

## Interface
- `LEN_W`, 16: width of the transfer length and counters.
- `BUF_DEPTH`, 3: output buffer entries. Minimum 2. A value of 3 or more is needed for one byte per cycle.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: command strobe, sampled only in IDLE.
- `len` in LEN_W: byte count, captured with `start`.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle completion pulse.
- `fifo_read_en` out 1: read request to the FIFO.
- `fifo_data_out` in 8: FIFO read data.
- `fifo_read_valid` in 1: FIFO read data valid. It arrives exactly one cycle after an accepted `fifo_read_en`. It stays low if the FIFO was empty.
- `m_data` out 8: output byte.
- `m_valid` out 1: output valid.
- `m_ready` in 1: downstream ready.
- `stat_bytes` out 32: present only with the stats macro. Bytes delivered.
- `stat_misses` out 32: present only with the stats macro. Read requests that returned no data.

## Operation
- States: IDLE, DRAIN, FLUSH.
- IDLE:
  - `start` with `len`≠0 captures `remaining`=`len` and moves to DRAIN.
  - `start` with `len`=0 pulses `done` the next cycle and stays in IDLE.
- DRAIN:
  - `fifo_read_en` = (`remaining` > `inflight`) && (`occ` + `inflight` < BUF_DEPTH).
  - All terms are registered, so there is no combinational path from `m_ready` or `fifo_read_valid` to `fifo_read_en`.
  - `inflight` is `fifo_read_en` delayed one cycle.
  - When `inflight` && `fifo_read_valid`: push `fifo_data_out` into the buffer and decrement `remaining`.
  - When `inflight` && !`fifo_read_valid`: this is a miss. `remaining` is unchanged and the byte is re-requested on a later cycle.
  - `fifo_read_valid` without `inflight` is ignored.
  - When `remaining` reaches 0, move to FLUSH.
- FLUSH:
  - No reads are issued.
  - When `occ`=0, pulse `done` and return to IDLE.
- Output buffer:
  - FIFO ordered.
  - `m_valid` = (`occ`≠0). `m_data` = head entry.
  - A pop occurs on `m_valid` && `m_ready`.
  - Push and pop in the same cycle leave `occ` unchanged.
  - `m_data` is held stable while `m_valid` && !`m_ready`.
- `start` while `busy` is ignored.
- `busy` is high in DRAIN and FLUSH.

## Timing
- Reset values:
  - State IDLE.
  - `busy`=0, `done`=0, `fifo_read_en`=0, `m_valid`=0, `m_data`=0.
  - `remaining`=0, `inflight`=0, `occ`=0.
  - Stats counters =0.
- Reset is asynchronous and takes effect immediately, including mid-transfer. Buffered bytes are discarded.
- Cycle-level latency:
  - `start` sampled at edge N.
  - `busy` and the first `fifo_read_en` appear in cycle N+1.
  - `fifo_read_valid` arrives in N+2.
  - `m_valid` is asserted in N+3.
- Throughput: with `m_ready`=1, a never-empty FIFO and BUF_DEPTH≥3, one byte per cycle.
- `done` is asserted the cycle after the final output handshake.
- `busy` falls together with `done`.

## Configuration
- `FIFO_READER_STATS_EN` defined:
  - `stat_bytes` increments on every output handshake.
  - `stat_misses` increments on every `inflight` && !`fifo_read_valid`.
  - Both counters wrap at 2^32 and are never cleared except by reset.
- Undefined: the stats ports and counters are absent. All other behaviour is identical.

## Structure
- Package `fifo_reader_pkg` holds:
  - The state enum (IDLE, DRAIN, FLUSH).
  - `FIFO_DATA_W`=8.
  - `STAT_W`=32.
- Sub-module `fifo_reader_buf` implements the BUF_DEPTH output ring buffer:
  - Signals: push, pop, `occ`, head data.
  - Wrap-around pointers.
  - `occ` sized to $clog2(BUF_DEPTH+1).

## Test plan
- `len`=5, FIFO preloaded 0..4, `m_ready`=1 -> `m_data` 0,1,2,3,4 on consecutive cycles. Exactly 5 `fifo_read_en` pulses. `done` one cycle after the last byte.
- `len`=4, FIFO holds 2 bytes, 2 more written 10 cycles later -> first 2 bytes delivered, then misses while empty, then all 4 delivered in order. `stat_misses`>0 with the macro defined.
- `len`=8, `m_ready`=0 for 20 cycles, then 1 -> `fifo_read_en` stops once `occ`+`inflight`=3. `m_data` is stable while stalled. All 8 bytes are delivered in order.
- `len`=0 -> `done` pulse one cycle later, no `fifo_read_en`, `busy` stays 0.
- `rst_n` asserted mid-transfer at byte 3 of 6 -> all outputs immediately 0, state IDLE. A new `start` `len`=2 drains the next 2 FIFO bytes correctly.
- `start` pulsed again during DRAIN -> ignored, and the transfer still delivers exactly the original `len`.

Source files
------------

// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared widths and FSM state type for the fifo_reader slice.
//   FIFO_DATA_W : byte width of the FIFO read port and output stream
//   STAT_W      : width of the optional statistics counters
//   state_e     : reader FSM states (IDLE, DRAIN, FLUSH)
package fifo_reader_pkg;

  localparam int unsigned FIFO_DATA_W = 8;
  localparam int unsigned STAT_W      = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/fifo_reader_buf.sv
// fifo_reader_buf: small ring buffer that decouples FIFO read latency from the
// downstream valid/ready handshake. Head valid and head data are registered.
//   clk, rst_n  : clock, async active-low reset
//   push        : write push_data (caller guarantees space)
//   push_data   : byte to store
//   pop         : consume head entry (caller guarantees head_valid)
//   occ         : registered entry count
//   head_valid  : registered (occ != 0)
//   head_data   : registered oldest entry, held while not popped
module fifo_reader_buf
  import fifo_reader_pkg::*;
#(
  parameter  int unsigned DEPTH = 3,
  localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [FIFO_DATA_W-1:0] push_data,
  input  logic                   pop,
  output logic [OCC_W-1:0]       occ,
  output logic                   head_valid,
  output logic [FIFO_DATA_W-1:0] head_data
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [FIFO_DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr_nx;
  logic [PTR_W-1:0]       wr_ptr_nx;
  logic [OCC_W-1:0]       occ_nx;
  logic [FIFO_DATA_W-1:0] head_nx;

  // Pointer increment with wrap at DEPTH (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next pointers, occupancy and head; the head bypasses the array when the
  // entry being written becomes the new head in the same cycle.
  always_comb begin
    rd_ptr_nx = pop  ? ptr_inc(rd_ptr) : rd_ptr;
    wr_ptr_nx = push ? ptr_inc(wr_ptr) : wr_ptr;
    occ_nx    = occ;
    if (push && !pop) begin
      occ_nx = occ + OCC_W'(1);
    end else if (pop && !push) begin
      occ_nx = occ - OCC_W'(1);
    end
    head_nx = (push && (wr_ptr == rd_ptr_nx)) ? push_data : mem[rd_ptr_nx];
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, count and registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      occ        <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      rd_ptr     <= rd_ptr_nx;
      wr_ptr     <= wr_ptr_nx;
      occ        <= occ_nx;
      head_valid <= (occ_nx != '0);
      if (occ_nx != '0) begin
        head_data <= head_nx;
      end
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: read-side master for the byte FIFO. On start it drains exactly
// len bytes, retrying reads that find the FIFO empty, and presents them on a
// valid/ready stream through a BUF_DEPTH-entry output buffer.
// Optional statistics counters are built when FIFO_READER_STATS_EN is defined.
//   clk, rst_n       : clock, async active-low reset
//   start, len       : command strobe and byte count (sampled in IDLE)
//   busy, done       : transfer in progress, one-cycle completion pulse
//   fifo_read_en     : FIFO read request (registered)
//   fifo_data_out    : FIFO read data
//   fifo_read_valid  : FIFO read data valid, one cycle after a request
//   m_data, m_valid  : output stream byte and valid
//   m_ready          : downstream ready
//   stat_bytes       : (FIFO_READER_STATS_EN) bytes delivered
//   stat_misses      : (FIFO_READER_STATS_EN) requests that returned no data
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned BUF_DEPTH = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [LEN_W-1:0]       len,
  output logic                   busy,
  output logic                   done,
  output logic                   fifo_read_en,
  input  logic [FIFO_DATA_W-1:0] fifo_data_out,
  input  logic                   fifo_read_valid,
  output logic [FIFO_DATA_W-1:0] m_data,
  output logic                   m_valid,
  input  logic                   m_ready
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [STAT_W-1:0]      stat_bytes,
  output logic [STAT_W-1:0]      stat_misses
`endif
);

  localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned SUM_W = OCC_W + 1;

  state_e           state;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] rem_nx;
  logic             inflight;
  logic             push;
  logic             pop;
  logic             drain_nx;
  logic             rd_en_nx;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occ_nx;

  // A read returns data only for a request we actually issued.
  assign push = inflight && fifo_read_valid;
  assign pop  = m_valid && m_ready;

  fifo_reader_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  (fifo_data_out),
    .pop        (pop),
    .occ        (occ),
    .head_valid (m_valid),
    .head_data  (m_data)
  );

  // Buffer occupancy after this edge.
  always_comb begin
    occ_nx = occ;
    if (push && !pop) begin
      occ_nx = occ + OCC_W'(1);
    end else if (pop && !push) begin
      occ_nx = occ - OCC_W'(1);
    end
  end

  // Next remaining count and read request. The request is evaluated on the
  // post-edge values so it behaves exactly like a function of registered
  // state, with no path from m_ready or fifo_read_valid to the pin.
  always_comb begin
    rem_nx   = remaining;
    drain_nx = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && (len != '0)) begin
          rem_nx   = len;
          drain_nx = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (push) begin
          rem_nx = remaining - LEN_W'(1);
        end
        drain_nx = (rem_nx != '0);
      end
      default: begin
        drain_nx = 1'b0;
      end
    endcase
    // inflight after the edge equals the current request.
    rd_en_nx = drain_nx
            && (rem_nx > LEN_W'(fifo_read_en))
            && ((SUM_W'(occ_nx) + SUM_W'(fifo_read_en)) < SUM_W'(BUF_DEPTH));
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      remaining    <= '0;
      inflight     <= 1'b0;
      fifo_read_en <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      remaining    <= rem_nx;
      inflight     <= fifo_read_en;
      fifo_read_en <= rd_en_nx;
      done         <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              state <= ST_DRAIN;
              busy  <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          // The final push always leaves at least one byte buffered.
          if (rem_nx == '0) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (occ_nx == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_READER_STATS_EN
  logic miss;
  assign miss = inflight && !fifo_read_valid;

  // Free-running statistics, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_bytes  <= '0;
      stat_misses <= '0;
    end else begin
      if (pop) begin
        stat_bytes <= stat_bytes + STAT_W'(1);
      end
      if (miss) begin
        stat_misses <= stat_misses + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed self-checking bench for fifo_reader with a
// behavioural one-cycle-latency byte FIFO on the read side.
module tb_fifo_reader;

  localparam int unsigned LEN_W     = 16;
  localparam int unsigned BUF_DEPTH = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             busy;
  logic             done;
  logic             fifo_read_en;
  logic [7:0]       fifo_data_out = 8'h00;
  logic             fifo_read_valid = 1'b0;
  logic [7:0]       m_data;
  logic             m_valid;
  logic             m_ready = 1'b0;
`ifdef FIFO_READER_STATS_EN
  logic [31:0]      stat_bytes;
  logic [31:0]      stat_misses;
`endif

  fifo_reader #(
    .LEN_W     (LEN_W),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .len             (len),
    .busy            (busy),
    .done            (done),
    .fifo_read_en    (fifo_read_en),
    .fifo_data_out   (fifo_data_out),
    .fifo_read_valid (fifo_read_valid),
    .m_data          (m_data),
    .m_valid         (m_valid),
    .m_ready         (m_ready)
`ifdef FIFO_READER_STATS_EN
    ,
    .stat_bytes      (stat_bytes),
    .stat_misses     (stat_misses)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: data returns one cycle after an accepted read.
  logic [7:0] fmem [256];
  logic [7:0] wr_idx = 8'd0;
  logic [7:0] rd_idx = 8'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_read_valid <= 1'b0;
    end else if (fifo_read_en && (rd_idx != wr_idx)) begin
      fifo_read_valid <= 1'b1;
      fifo_data_out   <= fmem[rd_idx];
      rd_idx          <= rd_idx + 8'd1;
    end else begin
      fifo_read_valid <= 1'b0;
    end
  end

  // Monitor, sampled on the falling edge.
  int         cyc = 0;
  logic [7:0] out_data [256];
  int         out_cyc [256];
  int         out_n = 0;
  int         done_n = 0;
  int         done_cyc = 0;
  int         en_n = 0;
  int         stab_err = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      out_data[8'(out_n)] <= m_data;
      out_cyc[8'(out_n)]  <= cyc;
      out_n               <= out_n + 1;
    end
    if (done) begin
      done_n   <= done_n + 1;
      done_cyc <= cyc;
    end
    if (fifo_read_en) en_n <= en_n + 1;
    if (m_valid && prev_stall && (m_data !== prev_data)) stab_err <= stab_err + 1;
    prev_stall <= m_valid && !m_ready;
    prev_data  <= m_data;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fifo(input logic [7:0] d);
    fmem[wr_idx] = d;
    wr_idx = wr_idx + 8'd1;
  endtask

  // Pulse start for one cycle; returns cyc just after the sampling edge.
  task automatic pulse_start(input logic [LEN_W-1:0] l, output int s);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_done(input int base, input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_n > base) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %0b want 0", done); else n_pass++;
    n_total++; if (fifo_read_en !== 1'b0) $display("FAIL reset_rd_en: got %0b want 0", fifo_read_en); else n_pass++;
    n_total++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %0b want 0", m_valid); else n_pass++;
    n_total++; if (m_data !== 8'h00) $display("FAIL reset_m_data: got %02h want 00", m_data); else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int ob, eb, db, s;
    bit to;
`ifdef FIFO_READER_STATS_EN
    logic [31:0] sb;
    sb = stat_bytes;
`endif
    for (int i = 0; i < 5; i++) push_fifo(8'(i));
    m_ready = 1'b1;
    ob = out_n; eb = en_n; db = done_n;
    pulse_start(16'd5, s);
    n_total++; if (busy !== 1'b1) $display("FAIL basic_busy_lat: got %0b want 1", busy); else n_pass++;
    n_total++; if (fifo_read_en !== 1'b1) $display("FAIL basic_rd_en_lat: got %0b want 1", fifo_read_en); else n_pass++;
    wait_done(db, 40, to);
    n_total++; if (to !== 1'b0) $display("FAIL basic_timeout: got %0b want 0", to); else n_pass++;
    n_total++; if (out_n - ob !== 5) $display("FAIL basic_count: got %0d want 5", out_n - ob); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_total++; if (out_data[8'(ob + i)] !== 8'(i)) $display("FAIL basic_data[%0d]: got %02h want %02h", i, out_data[8'(ob + i)], 8'(i)); else n_pass++;
      n_total++; if (out_cyc[8'(ob + i)] !== s + 2 + i) $display("FAIL basic_cycle[%0d]: got %0d want %0d", i, out_cyc[8'(ob + i)], s + 2 + i); else n_pass++;
    end
    n_total++; if (en_n - eb !== 5) $display("FAIL basic_rd_pulses: got %0d want 5", en_n - eb); else n_pass++;
    n_total++; if (done_cyc !== out_cyc[8'(ob + 4)] + 1) $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc, out_cyc[8'(ob + 4)] + 1); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL basic_busy_end: got %0b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL basic_done_single: got %0b want 0", done); else n_pass++;
`ifdef FIFO_READER_STATS_EN
    n_total++; if (stat_bytes - sb !== 32'd5) $display("FAIL basic_stat_bytes: got %0d want 5", stat_bytes - sb); else n_pass++;
`endif
  endtask

  task automatic test_misses();
    int ob, eb, db, s;
    bit to;
`ifdef FIFO_READER_STATS_EN
    logic [31:0] smb;
    smb = stat_misses;
`endif
    push_fifo(8'h10); push_fifo(8'h11);
    m_ready = 1'b1;
    ob = out_n; eb = en_n; db = done_n;
    pulse_start(16'd4, s);
    repeat (10) tick();
    push_fifo(8'h12); push_fifo(8'h13);
    wait_done(db, 60, to);
    n_total++; if (to !== 1'b0) $display("FAIL miss_timeout: got %0b want 0", to); else n_pass++;
    n_total++; if (out_n - ob !== 4) $display("FAIL miss_count: got %0d want 4", out_n - ob); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (out_data[8'(ob + i)] !== 8'(8'h10 + i)) $display("FAIL miss_data[%0d]: got %02h want %02h", i, out_data[8'(ob + i)], 8'(8'h10 + i)); else n_pass++;
    end
    n_total++; if ((en_n - eb > 4) !== 1'b1) $display("FAIL miss_retries: got %0d reads want more than 4", en_n - eb); else n_pass++;
    n_total++; if (rd_idx !== wr_idx) $display("FAIL miss_overread: got rd %0d want %0d", rd_idx, wr_idx); else n_pass++;
`ifdef FIFO_READER_STATS_EN
    n_total++; if (stat_misses - smb !== 32'(en_n - eb - 4)) $display("FAIL miss_stat: got %0d want %0d", stat_misses - smb, en_n - eb - 4); else n_pass++;
`endif
  endtask

  task automatic test_backpressure();
    int ob, eb, db, s, sb;
    bit to;
    for (int i = 0; i < 8; i++) push_fifo(8'(8'h20 + i));
    m_ready = 1'b0;
    ob = out_n; eb = en_n; db = done_n; sb = stab_err;
    pulse_start(16'd8, s);
    repeat (20) tick();
    n_total++; if (en_n - eb !== 3) $display("FAIL bp_reads_stalled: got %0d want 3", en_n - eb); else n_pass++;
    n_total++; if (fifo_read_en !== 1'b0) $display("FAIL bp_rd_en_stalled: got %0b want 0", fifo_read_en); else n_pass++;
    n_total++; if (m_valid !== 1'b1) $display("FAIL bp_m_valid: got %0b want 1", m_valid); else n_pass++;
    n_total++; if (m_data !== 8'h20) $display("FAIL bp_head: got %02h want 20", m_data); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL bp_busy: got %0b want 1", busy); else n_pass++;
    m_ready = 1'b1;
    wait_done(db, 60, to);
    n_total++; if (to !== 1'b0) $display("FAIL bp_timeout: got %0b want 0", to); else n_pass++;
    n_total++; if (out_n - ob !== 8) $display("FAIL bp_count: got %0d want 8", out_n - ob); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_total++; if (out_data[8'(ob + i)] !== 8'(8'h20 + i)) $display("FAIL bp_data[%0d]: got %02h want %02h", i, out_data[8'(ob + i)], 8'(8'h20 + i)); else n_pass++;
    end
    n_total++; if (en_n - eb !== 8) $display("FAIL bp_reads_total: got %0d want 8", en_n - eb); else n_pass++;
    n_total++; if (stab_err - sb !== 0) $display("FAIL bp_stable: got %0d changes want 0", stab_err - sb); else n_pass++;
  endtask

  task automatic test_zero_len();
    int eb, db, s;
    eb = en_n; db = done_n;
    pulse_start(16'd0, s);
    n_total++; if (done !== 1'b1) $display("FAIL zero_done: got %0b want 1", done); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL zero_busy: got %0b want 0", busy); else n_pass++;
    tick();
    n_total++; if (done !== 1'b0) $display("FAIL zero_done_pulse: got %0b want 0", done); else n_pass++;
    repeat (3) tick();
    n_total++; if (en_n - eb !== 0) $display("FAIL zero_reads: got %0d want 0", en_n - eb); else n_pass++;
    n_total++; if (done_n - db !== 1) $display("FAIL zero_done_count: got %0d want 1", done_n - db); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL zero_busy_after: got %0b want 0", busy); else n_pass++;
  endtask

  task automatic test_start_ignored();
    int ob, eb, db, s;
    bit to;
    for (int i = 0; i < 4; i++) push_fifo(8'(8'h40 + i));
    m_ready = 1'b1;
    ob = out_n; eb = en_n; db = done_n;
    pulse_start(16'd4, s);
    tick();
    start = 1'b1;
    len   = 16'd9;
    tick();
    start = 1'b0;
    wait_done(db, 40, to);
    n_total++; if (to !== 1'b0) $display("FAIL ign_timeout: got %0b want 0", to); else n_pass++;
    repeat (5) tick();
    n_total++; if (out_n - ob !== 4) $display("FAIL ign_count: got %0d want 4", out_n - ob); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (out_data[8'(ob + i)] !== 8'(8'h40 + i)) $display("FAIL ign_data[%0d]: got %02h want %02h", i, out_data[8'(ob + i)], 8'(8'h40 + i)); else n_pass++;
    end
    n_total++; if (en_n - eb !== 4) $display("FAIL ign_reads: got %0d want 4", en_n - eb); else n_pass++;
    n_total++; if (done_n - db !== 1) $display("FAIL ign_done_count: got %0d want 1", done_n - db); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL ign_busy: got %0b want 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int ob, db, s;
    bit to;
    logic [7:0] exp0, exp1;
    for (int i = 0; i < 8; i++) push_fifo(8'(8'h50 + i));
    m_ready = 1'b1;
    ob = out_n;
    pulse_start(16'd6, s);
    to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_n - ob >= 3) begin
        to = 1'b0;
        break;
      end
    end
    n_total++; if (to !== 1'b0) $display("FAIL rmid_timeout: got %0b want 0", to); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %0b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL rmid_done: got %0b want 0", done); else n_pass++;
    n_total++; if (fifo_read_en !== 1'b0) $display("FAIL rmid_rd_en: got %0b want 0", fifo_read_en); else n_pass++;
    n_total++; if (m_valid !== 1'b0) $display("FAIL rmid_m_valid: got %0b want 0", m_valid); else n_pass++;
    n_total++; if (m_data !== 8'h00) $display("FAIL rmid_m_data: got %02h want 00", m_data); else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    n_total++; if (out_n - ob !== 3) $display("FAIL rmid_delivered: got %0d want 3", out_n - ob); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (out_data[8'(ob + i)] !== 8'(8'h50 + i)) $display("FAIL rmid_pre[%0d]: got %02h want %02h", i, out_data[8'(ob + i)], 8'(8'h50 + i)); else n_pass++;
    end
    exp0 = fmem[rd_idx];
    exp1 = fmem[rd_idx + 8'd1];
    ob = out_n; db = done_n;
    pulse_start(16'd2, s);
    wait_done(db, 40, to);
    n_total++; if (to !== 1'b0) $display("FAIL rmid2_timeout: got %0b want 0", to); else n_pass++;
    n_total++; if (out_n - ob !== 2) $display("FAIL rmid2_count: got %0d want 2", out_n - ob); else n_pass++;
    n_total++; if (out_data[8'(ob)] !== exp0) $display("FAIL rmid2_data0: got %02h want %02h", out_data[8'(ob)], exp0); else n_pass++;
    n_total++; if (out_data[8'(ob + 1)] !== exp1) $display("FAIL rmid2_data1: got %02h want %02h", out_data[8'(ob + 1)], exp1); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_misses();
    test_backpressure();
    test_zero_len();
    test_start_ignored();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
